// File: rtl/tristate_bus_tx.sv
// ---------------------------------------------------------------------------
// tristate_bus_tx
// Serial frame transmitter that feeds the shared tri-state bus buffer.
// A frame is one start bit (0), DATA_W data bits (LSB first) and one stop
// bit (1). Each bit lasts BIT_CYCLES clocks. After the frame, bus_en stays
// low for GAP_CYCLES clocks so that another driver can take the line.
//
// Handshake: in_valid/in_ready follow strict valid/ready semantics. A word
// is accepted at a rising edge where in_valid and in_ready are both high.
// in_ready is high only in IDLE. While busy, in_valid is ignored: the word
// is neither dropped nor queued, because upstream keeps holding it.
//
// bus_en, bus_data and done are registered. Their next values are decoded
// from the next-state values, so the bus pins change only on clk edges.
// in_ready and busy are decoded directly from the state register.
// ---------------------------------------------------------------------------
module tristate_bus_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              bus_en,
    output logic              bus_data,
    output logic              busy,
    output logic              done
);

    // Counter widths: each counter runs 0..LAST inside its own state.
    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [BW-1:0] BIT_ONE = BW'(1);
    localparam logic [GW-1:0] GAP_ONE = GW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Current state and working registers. The state register is named
    // plainly so checkers can bind to it hierarchically.
    state_t              state;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bit_idx;
    logic [GW-1:0]       gap_cnt;
    logic [DATA_W-1:0]   shift;

    // Next values from the next-state process.
    state_t              state_n;
    logic [CW-1:0]       cnt_n;
    logic [BW-1:0]       bit_idx_n;
    logic [GW-1:0]       gap_cnt_n;
    logic [DATA_W-1:0]   shift_n;

    // Next values of the registered outputs.
    logic                bus_en_n;
    logic                bus_data_n;
    logic                done_n;

    logic                accept;
    logic                bit_end;

    assign accept  = in_valid & in_ready;
    assign bit_end = (cnt == CNT_LAST);

    // State register, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            gap_cnt  <= '0;
            shift    <= '0;
            bus_en   <= 1'b0;
            bus_data <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            gap_cnt  <= gap_cnt_n;
            shift    <= shift_n;
            bus_en   <= bus_en_n;
            bus_data <= bus_data_n;
            done     <= done_n;
        end
    end

    // Next-state logic: walk the frame bit by bit; every counter restarts
    // at zero when its state is entered and stops at its last value.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        gap_cnt_n = gap_cnt;
        shift_n   = shift;
        case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_idx_n = '0;
                gap_cnt_n = '0;
                if (accept) begin
                    state_n = START;
                    shift_n = in_data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shift_n = shift >> 1;
                    if (bit_idx == BIT_LAST) begin
                        state_n   = STOP;
                        bit_idx_n = '0;
                    end else begin
                        bit_idx_n = bit_idx + BIT_ONE;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n   = GAP;
                    cnt_n     = '0;
                    gap_cnt_n = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n   = IDLE;
                    gap_cnt_n = '0;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_ONE;
                end
            end
            default: begin
                state_n   = IDLE;
                cnt_n     = '0;
                bit_idx_n = '0;
                gap_cnt_n = '0;
                shift_n   = '0;
            end
        endcase
    end

    // Output decode from the next-state values, so the registered bus pins
    // line up with the state they belong to.
    always_comb begin
        bus_en_n   = 1'b0;
        bus_data_n = 1'b0;
        done_n     = 1'b0;
        case (state_n)
            START: begin
                bus_en_n   = 1'b1;
                bus_data_n = 1'b0;
            end
            DATA: begin
                bus_en_n   = 1'b1;
                bus_data_n = shift_n[0];
            end
            STOP: begin
                bus_en_n   = 1'b1;
                bus_data_n = 1'b1;
            end
            GAP: begin
                done_n = (gap_cnt_n == GAP_LAST);
            end
            default: begin
                bus_en_n   = 1'b0;
                bus_data_n = 1'b0;
                done_n     = 1'b0;
            end
        endcase
    end

    // Handshake and status flags decoded straight from the state register.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_tristate_bus_tx.sv
// ---------------------------------------------------------------------------
// tb_tristate_bus_tx
// Bench for tristate_bus_tx. The main instance uses default parameters and
// is checked every clock against a frame-level reference model: on each
// accept the model expands the word into its full per-clock waveform in a
// queue. A second instance (DATA_W=4, BIT_CYCLES=1, GAP_CYCLES=1) covers the
// minimal-timing frame. Outputs are sampled on the falling edge, inputs are
// driven on the falling edge.
// ---------------------------------------------------------------------------
module tb_tristate_bus_tx;

    localparam int DW  = 8;
    localparam int BC  = 4;
    localparam int GC  = 2;
    localparam int FRAME_EN = (DW + 2) * BC;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          bus_en;
    logic          bus_data;
    logic          busy;
    logic          done;

    logic          rst2_n;
    logic          valid2;
    logic [3:0]    data2;
    logic          ready2;
    logic          en2;
    logic          dat2;
    logic          busy2;
    logic          done2;

    tristate_bus_tx #(.DATA_W(DW), .BIT_CYCLES(BC), .GAP_CYCLES(GC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .bus_en   (bus_en),
        .bus_data (bus_data),
        .busy     (busy),
        .done     (done)
    );

    tristate_bus_tx #(.DATA_W(4), .BIT_CYCLES(1), .GAP_CYCLES(1)) dut2 (
        .clk      (clk),
        .rst_n    (rst2_n),
        .in_valid (valid2),
        .in_data  (data2),
        .in_ready (ready2),
        .bus_en   (en2),
        .bus_data (dat2),
        .busy     (busy2),
        .done     (done2)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    // Expected {bus_en, bus_data, done} for each upcoming clock of a frame.
    // Empty queue means the transmitter should be idle.
    logic [2:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand one word into its frame waveform straight from the frame rules.
    task automatic push_frame(input logic [DW-1:0] word);
        for (int i = 0; i < FRAME_EN; i++) begin
            int  b;
            logic v;
            b = i / BC;
            if (b == 0)           v = 1'b0;
            else if (b == DW + 1) v = 1'b1;
            else                  v = word[b-1];
            exp_q.push_back({1'b1, v, 1'b0});
        end
        for (int g = 0; g < GC; g++)
            exp_q.push_back({1'b0, 1'b0, (g == GC - 1) ? 1'b1 : 1'b0});
    endtask

    // Model update at a rising edge.
    task automatic model_edge();
        if (!rst_n) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (in_valid) begin
            push_frame(in_data);
        end
    endtask

    task automatic check_model();
        logic [2:0] e;
        logic       idle;
        idle = (exp_q.size() == 0);
        e    = idle ? 3'b000 : exp_q[0];
        chk("m_bus_en",   {31'd0, bus_en},   {31'd0, e[2]});
        chk("m_bus_data", {31'd0, bus_data}, {31'd0, e[1]});
        chk("m_done",     {31'd0, done},     {31'd0, e[0]});
        chk("m_in_ready", {31'd0, in_ready}, {31'd0, idle});
        chk("m_busy",     {31'd0, busy},     {31'd0, !idle});
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive inputs, take one rising edge, update
    // the model, then check at the next falling edge.
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic r);
        in_valid = v;
        in_data  = d;
        rst_n    = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            tick(1'b0, DW'($urandom), 1'b1);
    endtask

    // ---------------- table for the A5 frame ----------------
    typedef struct {
        logic          rst_n;
        logic          valid;
        logic [DW-1:0] data;
        logic          en;
        logic          dat;
        logic          dn;
        logic          rdy;
    } vec_t;

    vec_t tbl[44];

    logic       en_log[0:99];
    logic       dat_log[0:99];

    initial begin
        logic [9:0] grp;
        logic [5:0] pat;
        int         first_low;
        int         lows;
        int         s;
        logic [7:0] second;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rst2_n   = 1'b0;
        valid2   = 1'b0;
        data2    = '0;

        // Fill the table: expected bus_data per 4-clock group for 8'hA5.
        grp = 10'b1101001010;
        tbl[0] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 1; k <= 40; k++)
            tbl[k] = '{1'b1, 1'b0, 8'h3C, 1'b1, grp[(k-1)/4], 1'b0, 1'b0};
        tbl[41] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[42] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[43] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

        // Test 1: reset for two clocks.
        @(negedge clk);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_bus_en",   {31'd0, bus_en},   32'd0);
        chk("rst_bus_data", {31'd0, bus_data}, 32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_done",     {31'd0, done},     32'd0);
        rst2_n = 1'b1;
        tick(1'b0, 8'h00, 1'b1);

        // Test 2: table-driven A5 frame.
        for (int k = 0; k < 44; k++) begin
            chk("tbl_bus_en",   {31'd0, bus_en},   {31'd0, tbl[k].en});
            chk("tbl_bus_data", {31'd0, bus_data}, {31'd0, tbl[k].dat});
            chk("tbl_done",     {31'd0, done},     {31'd0, tbl[k].dn});
            chk("tbl_in_ready", {31'd0, in_ready}, {31'd0, tbl[k].rdy});
            tick(tbl[k].valid, tbl[k].data, tbl[k].rst_n);
        end
        drain();

        // Test 3: in_valid held high, 8'h00 then 8'hFF.
        tick(1'b1, 8'h00, 1'b1);
        en_log[0] = 1'b0; dat_log[0] = 1'b0;
        en_log[1] = bus_en; dat_log[1] = bus_data;
        for (int k = 2; k < 100; k++) begin
            tick(1'b1, 8'hFF, 1'b1);
            en_log[k] = bus_en; dat_log[k] = bus_data;
        end
        first_low = 1;
        while (first_low < 99 && en_log[first_low]) first_low++;
        lows = 0;
        s = first_low;
        while (s < 99 && !en_log[s]) begin lows++; s++; end
        chk("t3_first_len", first_low - 1, FRAME_EN);
        chk("t3_gap_len", lows, GC + 1);
        for (int b = 0; b < DW; b++) begin
            second[b] = 1'b1;
            for (int c = 0; c < BC; c++) begin
                int idx;
                idx = s + BC * (1 + b) + c;
                if (idx > 99 || !dat_log[idx] || !en_log[idx]) second[b] = 1'b0;
            end
        end
        chk("t3_second_bits", {24'd0, second}, 32'hFF);
        drain();

        // Test 4: input changes and in_valid pulses mid-frame are ignored.
        tick(1'b1, 8'h5A, 1'b1);
        for (int k = 0; k < 9; k++) tick(1'b0, 8'h5A, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick(k[0], DW'($urandom), 1'b1);
            chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
        end
        drain();
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 8'h00, 1'b1);
            chk("t4_no_second", {31'd0, bus_en}, 32'd0);
        end

        // Test 5: one-clock reset at clk 20 of a frame.
        tick(1'b1, 8'hC3, 1'b1);
        for (int k = 0; k < 19; k++) tick(1'b0, 8'h00, 1'b1);
        chk("t5_pre_en", {31'd0, bus_en}, 32'd1);
        tick(1'b0, 8'h00, 1'b0);
        chk("t5_en_drop", {31'd0, bus_en},   32'd0);
        chk("t5_ready",   {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 8'h00, 1'b1);
            chk("t5_no_done", {31'd0, done}, 32'd0);
        end
        tick(1'b1, 8'h96, 1'b1);
        drain();

        // Test 6: minimal timing instance, word 4'b0110.
        pat    = 6'b101100;
        valid2 = 1'b1;
        data2  = 4'b0110;
        tick(1'b0, 8'h00, 1'b1);
        valid2 = 1'b0;
        data2  = 4'b1001;
        for (int k = 1; k <= 6; k++) begin
            chk("t6_en",   {31'd0, en2},  32'd1);
            chk("t6_data", {31'd0, dat2}, {31'd0, pat[k-1]});
            tick(1'b0, 8'h00, 1'b1);
        end
        chk("t6_gap_en", {31'd0, en2},   32'd0);
        chk("t6_done",   {31'd0, done2}, 32'd1);
        tick(1'b0, 8'h00, 1'b1);
        chk("t6_ready",  {31'd0, ready2}, 32'd1);
        chk("t6_done_clr", {31'd0, done2}, 32'd0);

        // Randomized traffic with occasional resets, checked by the model.
        for (int k = 0; k < 800; k++)
            tick(1'($urandom_range(0, 1)), DW'($urandom),
                 ($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0);
        drain();
        tick(1'b0, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
